// File: rtl/product_drain.sv
// Times one compute window from the rising edge of enable, snapshots the product
// array at the end of it, then drains the snapshot one element per valid/ready beat.
module product_drain #(
  parameter  int DIM_A          = 8,
  parameter  int DIM_C          = 1,
  parameter  int ACC_WIDTH      = 12,
  parameter  int COMPUTE_CYCLES = 16,
  localparam int N              = DIM_A * DIM_C,
  localparam int IDX_W          = (N > 1) ? $clog2(N) : 1
) (
  input  logic                                        clk,
  input  logic                                        rst_n,
  input  logic                                        enable,
  input  logic [DIM_C-1:0][DIM_A-1:0][ACC_WIDTH-1:0]  product,
  output logic [ACC_WIDTH-1:0]                        out_data,
  output logic [IDX_W-1:0]                            out_idx,
  output logic                                        out_last,
  output logic                                        out_valid,
  input  logic                                        out_ready,
  output logic                                        busy,
  output logic                                        overrun
);

  localparam int CNT_W = (COMPUTE_CYCLES > 1) ? $clog2(COMPUTE_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, WAIT, DRAIN} state_t;

  state_t                           state_q, state_d;
  logic   [CNT_W-1:0]               cnt_q, cnt_d;
  logic   [IDX_W-1:0]               ptr_q, ptr_d;
  logic                             enable_q;
  logic                             overrun_q, overrun_d;
  logic                             capture;
  logic                             start;
  // Element k = c*DIM_A + a sits at the same bit offset as product[c][a].
  logic   [N-1:0][ACC_WIDTH-1:0]    data_buf;

  assign start = enable && !enable_q;

  // NOTE: every variable assigned here gets a default first, so no latch can be inferred.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    ptr_d     = ptr_q;
    overrun_d = overrun_q;
    capture   = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = WAIT;
          cnt_d   = '0;
        end
      end
      WAIT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_W'(COMPUTE_CYCLES - 1)) begin
          capture = 1'b1;
          ptr_d   = '0;
          state_d = DRAIN;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DRAIN: begin
        // A new window cannot start while the previous snapshot is still draining.
        if (start) overrun_d = 1'b1;
        if (out_ready) begin
          if (ptr_q == IDX_W'(N - 1)) state_d = IDLE;
          else                        ptr_d   = ptr_q + IDX_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      ptr_q     <= '0;
      enable_q  <= 1'b0;
      overrun_q <= 1'b0;
      // NOTE: the snapshot buffer is reset so a reset mid-window leaves no stale data behind.
      data_buf  <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      ptr_q     <= ptr_d;
      enable_q  <= enable;
      overrun_q <= overrun_d;
      if (capture) data_buf <= product;
    end
  end

  // Outputs decode only from registered state, so out_ready never reaches out_valid.
  assign out_valid = (state_q == DRAIN);
  assign out_data  = out_valid ? data_buf[ptr_q] : '0;
  assign out_idx   = out_valid ? ptr_q : '0;
  assign out_last  = out_valid && (ptr_q == IDX_W'(N - 1));
  assign busy      = (state_q != IDLE);
  assign overrun   = overrun_q;

endmodule
